// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped tagged BTB with saturating direction counters and mispredict statistics
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int TAG_BITS = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [31:0]      lookup_pc,
    output logic             predict_taken,
    output logic [31:0]      predict_target,
    input  logic             update_valid,
    input  logic [31:0]      update_pc,
    input  logic             update_taken,
    input  logic [31:0]      update_target,
    input  logic             update_pred_taken,
    input  logic [31:0]      update_pred_target,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] WNT = WT - CTR_BITS'(1);

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [CTR_BITS-1:0] r_ctr    [ENTRIES];
    logic [CNT_W-1:0]    r_branch_count;
    logic [CNT_W-1:0]    r_mispredict_count;

    logic [IDX_BITS-1:0] w_l_idx;
    logic [TAG_BITS-1:0] w_l_tag;
    logic [IDX_BITS-1:0] w_u_idx;
    logic [TAG_BITS-1:0] w_u_tag;
    logic                w_u_hit;
    logic [CTR_BITS-1:0] w_u_ctr;
    logic [CTR_BITS-1:0] w_u_ctr_next;
    logic                w_unused;

    assign w_l_idx  = lookup_pc[IDX_BITS+1:2];
    assign w_l_tag  = lookup_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
    assign w_u_idx  = update_pc[IDX_BITS+1:2];
    assign w_u_tag  = update_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
    assign w_unused = ^{lookup_pc, update_pc};

    always_comb begin
        predict_taken  = r_valid[w_l_idx] && (r_tag[w_l_idx] == w_l_tag) && r_ctr[w_l_idx][CTR_BITS-1];
        predict_target = predict_taken ? r_target[w_l_idx] : lookup_pc + 32'd4;
        mispredict     = update_valid && ((update_pred_taken != update_taken) ||
                                          (update_taken && (update_pred_target != update_target)));
        w_u_hit        = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
        w_u_ctr        = r_ctr[w_u_idx];
        w_u_ctr_next   = !w_u_hit ? WT :
                         update_taken ? (&w_u_ctr ? w_u_ctr : w_u_ctr + CTR_BITS'(1)) :
                                        (w_u_ctr == '0 ? w_u_ctr : w_u_ctr - CTR_BITS'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= WNT;
            end
        end else if (clr) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= WNT;
            end
        end else if (update_valid && (w_u_hit || update_taken)) begin
            r_valid[w_u_idx] <= 1'b1;
            r_tag[w_u_idx]   <= w_u_tag;
            r_ctr[w_u_idx]   <= w_u_ctr_next;
            if (update_taken) r_target[w_u_idx] <= update_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (update_valid && !(&r_branch_count)) r_branch_count <= r_branch_count + CNT_W'(1);
            if (mispredict && !(&r_mispredict_count)) r_mispredict_count <= r_mispredict_count + CNT_W'(1);
        end
    end

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, training, aliasing, clr and saturating statistics
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [31:0] lookup_pc = 32'h40;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = '0;
    logic        update_pred_taken = 1'b0;
    logic [31:0] update_pred_target = '0;
    logic        predict_taken, predict_taken3;
    logic [31:0] predict_target, predict_target3;
    logic        mispredict, mispredict3;
    logic [15:0] branch_count, mispredict_count;
    logic [2:0]  branch_count3, mispredict_count3;
    int vectors = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_mp = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst(rst), .clr(clr), .lookup_pc(lookup_pc),
        .predict_taken(predict_taken), .predict_target(predict_target),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_taken(update_pred_taken),
        .update_pred_target(update_pred_target), .mispredict(mispredict),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_predictor #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .clr(clr), .lookup_pc(lookup_pc),
        .predict_taken(predict_taken3), .predict_target(predict_target3),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_pred_taken(update_pred_taken),
        .update_pred_target(update_pred_target), .mispredict(mispredict3),
        .branch_count(branch_count3), .mispredict_count(mispredict_count3)
    );

    task automatic set_upd(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                           input logic pt, input logic [31:0] ptg);
        update_valid = 1'b1;
        update_pc = pc;
        update_taken = t;
        update_target = tg;
        update_pred_taken = pt;
        update_pred_target = ptg;
        exp_br++;
        if ((pt != t) || (t && ptg != tg)) exp_mp++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_reset;
        lookup_pc = 32'h40;
        update_valid = 1'b1;
        update_taken = 1'b1;
        update_pred_taken = 1'b0;
        #2;
        vectors++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
            errors++;
            $display("FAIL reset_lookup: got taken=%b target=%h, want 0/00000044", predict_taken, predict_target);
        end
        vectors++;
        if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: got br=%0d mp=%0d, want 0/0", branch_count, mispredict_count);
        end
        vectors++;
        if (mispredict !== 1'b1) begin
            errors++;
            $display("FAIL reset_mispredict: got %b, want 1", mispredict);
        end
        update_valid = 1'b0;
        #10;
        rst = 1'b0;
    endtask

    task automatic test_mispredict_comb;
        update_valid = 1'b1;
        update_taken = 1'b1;
        update_pred_taken = 1'b1;
        update_target = 32'h500;
        update_pred_target = 32'h500;
        #1;
        vectors++;
        if (mispredict !== 1'b0) begin
            errors++;
            $display("FAIL misp_correct: got %b, want 0", mispredict);
        end
        update_pred_target = 32'h504;
        #1;
        vectors++;
        if (mispredict !== 1'b1) begin
            errors++;
            $display("FAIL misp_target: got %b, want 1", mispredict);
        end
        update_taken = 1'b0;
        update_pred_taken = 1'b0;
        #1;
        vectors++;
        if (mispredict !== 1'b0) begin
            errors++;
            $display("FAIL misp_nt_ignores_target: got %b, want 0", mispredict);
        end
        update_valid = 1'b0;
        #1;
    endtask

    task automatic test_alloc;
        lookup_pc = 32'h40;
        set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        #1;
        vectors++;
        if (mispredict !== 1'b1) begin
            errors++;
            $display("FAIL alloc_mispredict: got %b, want 1", mispredict);
        end
        tick;
        vectors++;
        if (predict_taken !== 1'b1 || predict_target !== 32'h100) begin
            errors++;
            $display("FAIL alloc_lookup: got taken=%b target=%h, want 1/00000100", predict_taken, predict_target);
        end
        vectors++;
        if (mispredict_count !== 16'd1 || branch_count !== 16'd1) begin
            errors++;
            $display("FAIL alloc_counts: got br=%0d mp=%0d, want 1/1", branch_count, mispredict_count);
        end
    endtask

    task automatic test_saturate;
        lookup_pc = 32'h40;
        repeat (2) begin set_upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100); tick; end
        set_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100); tick;
        vectors++;
        if (predict_taken !== 1'b1) begin
            errors++;
            $display("FAIL sat_ctr2: got taken=%b, want 1 (ctr 3->2)", predict_taken);
        end
        set_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100); tick;
        vectors++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
            errors++;
            $display("FAIL sat_ctr1: got taken=%b target=%h, want 0/00000044", predict_taken, predict_target);
        end
        repeat (3) begin set_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0); tick; end
        set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); tick;
        vectors++;
        if (predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL sat_floor: got taken=%b, want 0 (ctr 0->1)", predict_taken);
        end
        set_upd(32'h40, 1'b1, 32'h180, 1'b0, 32'h0); tick;
        vectors++;
        if (predict_taken !== 1'b1 || predict_target !== 32'h180) begin
            errors++;
            $display("FAIL sat_retrain: got taken=%b target=%h, want 1/00000180", predict_taken, predict_target);
        end
        vectors++;
        if (branch_count !== 16'(exp_br) || mispredict_count !== 16'(exp_mp)) begin
            errors++;
            $display("FAIL sat_counts: got br=%0d mp=%0d, want %0d/%0d", branch_count, mispredict_count, exp_br, exp_mp);
        end
    endtask

    task automatic test_alias;
        lookup_pc = 32'h80;
        #1;
        vectors++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h84) begin
            errors++;
            $display("FAIL alias_miss: got taken=%b target=%h, want 0/00000084", predict_taken, predict_target);
        end
        set_upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h0); tick;
        vectors++;
        if (predict_taken !== 1'b1 || predict_target !== 32'h200) begin
            errors++;
            $display("FAIL alias_hit: got taken=%b target=%h, want 1/00000200", predict_taken, predict_target);
        end
        lookup_pc = 32'h40;
        #1;
        vectors++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
            errors++;
            $display("FAIL alias_evicted: got taken=%b target=%h, want 0/00000044", predict_taken, predict_target);
        end
    endtask

    task automatic test_same_cycle;
        lookup_pc = 32'h40;
        set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); tick;
        set_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
        #1;
        vectors++;
        if (predict_taken !== 1'b1 || predict_target !== 32'h100) begin
            errors++;
            $display("FAIL same_pre_edge: got taken=%b target=%h, want 1/00000100", predict_taken, predict_target);
        end
        tick;
        vectors++;
        if (predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL same_post_edge: got taken=%b, want 0", predict_taken);
        end
        set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); tick;
        clr = 1'b1;
        set_upd(32'h60, 1'b1, 32'h300, 1'b0, 32'h0); tick;
        lookup_pc = 32'h60;
        #1;
        vectors++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h64) begin
            errors++;
            $display("FAIL clr_discard: got taken=%b target=%h, want 0/00000064", predict_taken, predict_target);
        end
        lookup_pc = 32'h40;
        #1;
        vectors++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
            errors++;
            $display("FAIL clr_invalidate: got taken=%b target=%h, want 0/00000044", predict_taken, predict_target);
        end
        vectors++;
        if (branch_count !== 16'(exp_br) || mispredict_count !== 16'(exp_mp)) begin
            errors++;
            $display("FAIL clr_counts: got br=%0d mp=%0d, want %0d/%0d", branch_count, mispredict_count, exp_br, exp_mp);
        end
        set_upd(32'h40, 1'b1, 32'h120, 1'b0, 32'h0); tick;
        vectors++;
        if (predict_taken !== 1'b1 || predict_target !== 32'h120) begin
            errors++;
            $display("FAIL clr_realloc: got taken=%b target=%h, want 1/00000120", predict_taken, predict_target);
        end
    endtask

    task automatic test_cnt_saturate;
        tick;
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        exp_br = 0;
        exp_mp = 0;
        repeat (10) begin set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0); tick; end
        vectors++;
        if (branch_count3 !== 3'd7 || mispredict_count3 !== 3'd7) begin
            errors++;
            $display("FAIL cnt3_hold: got br=%0d mp=%0d, want 7/7", branch_count3, mispredict_count3);
        end
        vectors++;
        if (branch_count !== 16'd10 || mispredict_count !== 16'd10) begin
            errors++;
            $display("FAIL cnt16_ten: got br=%0d mp=%0d, want 10/10", branch_count, mispredict_count);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (branch_count3 !== 3'd0 || mispredict_count3 !== 3'd0 || branch_count !== 16'd0) begin
            errors++;
            $display("FAIL async_rst: got br3=%0d mp3=%0d br=%0d, want 0/0/0", branch_count3, mispredict_count3, branch_count);
        end
        vectors++;
        if (predict_taken !== 1'b0 || predict_target !== 32'h44) begin
            errors++;
            $display("FAIL async_rst_lookup: got taken=%b target=%h, want 0/00000044", predict_taken, predict_target);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset;
        test_mispredict_comb;
        test_alloc;
        test_saturate;
        test_alias;
        test_same_cycle;
        test_cnt_saturate;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage RV32 pipeline; replaces the implicit always-not-taken policy.
- Direct-mapped, tagged branch target buffer with per-entry saturating counters, parametrised in depth, counter width, tag width and statistics width.
- IF stage looks up the current PC combinationally and steers next_pc. MEM stage reports resolved branches/jumps back to the predictor.
- Saturating branch and mispredict statistics counters support performance evaluation.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, >=2; IDX_BITS = $clog2(ENTRIES)
CTR_BITS, 2, saturating counter width, >=1
TAG_BITS, 8, stored tag width; TAG_BITS + IDX_BITS <= 30
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous invalidate-all (fence.i / context switch)
lookup_pc  in  32  IF-stage PC
predict_taken  out  1  predicted taken for lookup_pc
predict_target  out  32  predicted next PC for lookup_pc
update_valid  in  1  a resolved control-flow instruction is in MEM this cycle
update_pc  in  32  PC of the resolved instruction
update_taken  in  1  actual outcome
update_target  in  32  actual target (valid when taken)
update_pred_taken  in  1  prediction that was made for this instruction
update_pred_target  in  32  predicted target that was used
mispredict  out  1  combinational: update_valid and the prediction was wrong
branch_count  out  CNT_W  resolved updates seen, saturating
mispredict_count  out  CNT_W  mispredictions seen, saturating

Behaviour:
- Address split:
  - idx = pc[IDX_BITS+1:2]
  - tag = pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2]
  - pc[1:0] is ignored.
- Per entry: valid (1), tag (TAG_BITS), target (32), ctr (CTR_BITS).
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx] == lookup tag).
  - predict_taken = hit & ctr[idx][CTR_BITS-1].
  - predict_target = target[idx] when predict_taken, else lookup_pc + 32'd4 (mod 2^32).
- mispredict = update_valid & ((update_pred_taken != update_taken) | (update_taken & (update_pred_target != update_target))).
- Update, on the rising edge when update_valid = 1 and clr = 0:
  - Hit, taken: ctr increments, saturating at all-ones; target <= update_target.
  - Hit, not taken: ctr decrements, saturating at 0; target is unchanged.
  - Miss, taken: allocate the entry, overwriting any aliased entry. valid <= 1, tag and target written, ctr <= weakly-taken (1 << (CTR_BITS-1)).
  - Miss, not taken: no change.
- Statistics, on the rising edge:
  - branch_count increments when update_valid = 1.
  - mispredict_count increments when mispredict = 1.
  - Both hold at 2^CNT_W - 1 (no wrap).
  - Statistics are updated even in a cycle where clr = 1.
- clr:
  - Clears every valid bit and resets every ctr to weakly-not-taken ((1 << (CTR_BITS-1)) - 1).
  - Targets, tags and statistics are untouched.
  - clr has priority over an update in the same cycle: the update is discarded.
- Simultaneous lookup and update to the same idx: lookup returns pre-edge state. There is no write-through bypass.
- rst (asynchronous, immediate):
  - All valid bits cleared; all ctr set to weakly-not-taken; targets and tags set to 0; both statistics counters set to 0.
  - Outputs after reset: predict_taken = 0, predict_target = lookup_pc + 4, mispredict reflects its inputs.
  - Assertion of rst mid-operation abandons any pending update in that cycle.
- CTR_BITS = 1: ctr is a last-outcome bit. Weakly-taken = 1, weakly-not-taken = 0.

Test Plan:
1. After rst, lookup_pc = 0x40 -> predict_taken = 0, predict_target = 0x44; branch_count = mispredict_count = 0.
2. Update pc 0x40, taken, target 0x100, pred_taken = 0 -> mispredict = 1 that cycle. Next cycle lookup 0x40 -> predict_taken = 1, target 0x100; mispredict_count = 1.
3. Saturation (defaults):
   - Two further taken updates at 0x40 -> ctr = 3.
   - Then two not-taken updates -> ctr = 1, lookup 0x40 predict_taken = 0.
   - Then three more not-taken updates -> ctr stays 0.
4. Aliasing with ENTRIES = 16:
   - 0x40 is allocated; lookup 0x80 (same idx 0, different tag) -> predict_taken = 0, target 0x84.
   - Taken update at 0x80 with target 0x200 -> 0x80 now hits with target 0x200; 0x40 now misses.
5. Same-cycle events:
   - Lookup 0x40 while a not-taken update on 0x40 moves ctr from 2 to 1 -> predict_taken = 1 that cycle, 0 the next.
   - clr asserted together with a taken update at 0x60 -> next cycle all lookups miss, branch_count still increments.
6. CNT_W = 3:
   - Ten mispredicting updates -> both counters hold at 7.
   - Pulse rst asynchronously between edges -> counters read 0 immediately, before the next edge.
